// File: rtl/ysyx_22050854_wb_arbiter_pkg.sv
// rtl/ysyx_22050854_wb_arbiter_pkg.sv - shared CPU constants and types for the writeback stage
package ysyx_22050854_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_LSU,
    GNT_EXU
  } grant_e;

  // x0 is architecturally constant, so a write to it is a no-op
  function automatic logic writes_reg(input logic wen, input reg_addr_t rd);
    return wen && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/ysyx_22050854_wb_arbiter_if.sv
// rtl/ysyx_22050854_wb_arbiter_if.sv - producer, decode and register-file signals of the writeback stage
interface ysyx_22050854_wb_arbiter_if
  import ysyx_22050854_wb_arbiter_pkg::*;
#(
  parameter int XLEN = ysyx_22050854_wb_arbiter_pkg::XLEN
);

  logic            exu_valid;
  logic            exu_ready;
  reg_addr_t       exu_rd;
  logic            exu_wen;
  logic [XLEN-1:0] exu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  reg_addr_t       lsu_rd;
  logic            lsu_wen;
  logic [XLEN-1:0] lsu_data;

  logic            iss_fire;
  reg_addr_t       iss_rd;
  logic            iss_wen;

  reg_addr_t       chk_rs1;
  reg_addr_t       chk_rs2;
  reg_addr_t       chk_rd;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            busy_rd;
  logic            fwd_en1;
  logic            fwd_en2;
  logic [XLEN-1:0] fwd_data;

  logic            wen;
  reg_addr_t       waddr;
  logic [XLEN-1:0] wdata;

  modport slave (
    input  exu_valid, exu_rd, exu_wen, exu_data,
    input  lsu_valid, lsu_rd, lsu_wen, lsu_data,
    input  iss_fire, iss_rd, iss_wen,
    input  chk_rs1, chk_rs2, chk_rd,
    output exu_ready, lsu_ready,
    output busy_rs1, busy_rs2, busy_rd, fwd_en1, fwd_en2, fwd_data,
    output wen, waddr, wdata
  );

  modport master (
    output exu_valid, exu_rd, exu_wen, exu_data,
    output lsu_valid, lsu_rd, lsu_wen, lsu_data,
    output iss_fire, iss_rd, iss_wen,
    output chk_rs1, chk_rs2, chk_rd,
    input  exu_ready, lsu_ready,
    input  busy_rs1, busy_rs2, busy_rd, fwd_en1, fwd_en2, fwd_data,
    input  wen, waddr, wdata
  );

endinterface

// File: rtl/ysyx_22050854_scoreboard.sv
// rtl/ysyx_22050854_scoreboard.sv - per-register pending bits with RAW/WAW lookup and commit bypass
module ysyx_22050854_scoreboard
  import ysyx_22050854_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en_i,
  input  reg_addr_t set_idx_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_idx_i,
  input  reg_addr_t chk_rs1_i,
  input  reg_addr_t chk_rs2_i,
  input  reg_addr_t chk_rd_i,
  output logic      busy_rs1_o,
  output logic      busy_rs2_o,
  output logic      busy_rd_o,
  output logic      fwd_en1_o,
  output logic      fwd_en2_o
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // Set is applied after clear so a re-issue in the clear cycle keeps the bit
  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) begin
      sb_d[clr_idx_i] = 1'b0;
    end
    if (set_en_i) begin
      sb_d[set_idx_i] = 1'b1;
    end
    sb_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // The write being committed this cycle still has its bit set; bypass it
  always_comb begin
    fwd_en1_o  = clr_en_i && (clr_idx_i == chk_rs1_i) && (chk_rs1_i != REG_ZERO);
    fwd_en2_o  = clr_en_i && (clr_idx_i == chk_rs2_i) && (chk_rs2_i != REG_ZERO);
    busy_rs1_o = sb_q[chk_rs1_i] && !fwd_en1_o;
    busy_rs2_o = sb_q[chk_rs2_i] && !fwd_en2_o;
    busy_rd_o  = sb_q[chk_rd_i];
  end

endmodule

// File: rtl/ysyx_22050854_wb_arbiter.sv
// rtl/ysyx_22050854_wb_arbiter.sv - EXU/LSU writeback arbiter with starvation guard and commit register
module ysyx_22050854_wb_arbiter
  import ysyx_22050854_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = ysyx_22050854_wb_arbiter_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_22050854_wb_arbiter_if.slave wb
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      starve_q, starve_d;
  logic            wen_q, wen_d;
  reg_addr_t       waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic   starved;
  logic   exu_ready;
  logic   lsu_ready;
  logic   exu_fire;
  logic   lsu_fire;
  grant_e grant;

  // LSU normally wins; a saturated counter hands EXU a single cycle of priority
  always_comb begin
    starved   = (starve_q == LIMIT);
    exu_ready = starved || !wb.lsu_valid;
    lsu_ready = !starved || !wb.exu_valid;
    exu_fire  = wb.exu_valid && exu_ready;
    lsu_fire  = wb.lsu_valid && lsu_ready;
    grant     = GNT_NONE;
    if (exu_fire) begin
      grant = GNT_EXU;
    end else if (lsu_fire) begin
      grant = GNT_LSU;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (exu_fire) begin
      starve_d = '0;
    end else if (wb.exu_valid && !exu_ready && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // waddr/wdata hold between writes so fwd_data stays equal to wdata
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (grant)
      GNT_EXU: begin
        if (writes_reg(wb.exu_wen, wb.exu_rd)) begin
          wen_d   = 1'b1;
          waddr_d = wb.exu_rd;
          wdata_d = wb.exu_data;
        end
      end
      GNT_LSU: begin
        if (writes_reg(wb.lsu_wen, wb.lsu_rd)) begin
          wen_d   = 1'b1;
          waddr_d = wb.lsu_rd;
          wdata_d = wb.lsu_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= REG_ZERO;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  logic busy_rs1, busy_rs2, busy_rd, fwd_en1, fwd_en2;

  ysyx_22050854_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (wb.iss_fire && wb.iss_wen),
    .set_idx_i  (wb.iss_rd),
    .clr_en_i   (wen_q),
    .clr_idx_i  (waddr_q),
    .chk_rs1_i  (wb.chk_rs1),
    .chk_rs2_i  (wb.chk_rs2),
    .chk_rd_i   (wb.chk_rd),
    .busy_rs1_o (busy_rs1),
    .busy_rs2_o (busy_rs2),
    .busy_rd_o  (busy_rd),
    .fwd_en1_o  (fwd_en1),
    .fwd_en2_o  (fwd_en2)
  );

  assign wb.exu_ready = exu_ready;
  assign wb.lsu_ready = lsu_ready;
  assign wb.wen       = wen_q;
  assign wb.waddr     = waddr_q;
  assign wb.wdata     = wdata_q;
  assign wb.fwd_data  = wdata_q;
  assign wb.busy_rs1  = busy_rs1;
  assign wb.busy_rs2  = busy_rs2;
  assign wb.busy_rd   = busy_rd;
  assign wb.fwd_en1   = fwd_en1;
  assign wb.fwd_en2   = fwd_en2;

endmodule
